// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port 32-bit RAM with byte-lane write enable
module dmem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    // Byte-lane write; contents deliberately have no reset
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder with wait states
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_t      r_state;
    dmem_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic             w_req_ready;
    logic             w_access;
    logic             w_err;
    logic             w_mem_we;
    logic [31:0]      w_rd_word;

    assign w_req_ready = (r_state == IDLE) && !rst;

    // Misaligned, or word index beyond the array capacity
    assign w_err = (r_addr[1:0] != 2'b00) || ((r_addr[31:2] >> ADDR_WIDTH) != '0);

    // Commit only on a clean WAIT exit; a reset on that same edge aborts the store
    assign w_mem_we = w_access && r_we && !w_err && !rst;

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_be    (r_be),
        .i_addr  (r_addr[ADDR_WIDTH+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_rd_word)
    );

    // Next-state and access strobe
    always_comb begin
        w_next_state = r_state;
        w_access     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && w_req_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_access     = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, capture registers, wait counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= CNT_LOAD;
            end
            if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_we) ? 32'h0 : w_rd_word;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   seen  = 0;
    exp_t sb[$];

    data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented response against the scoreboard head
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                if (!seen) begin
                    check("rsp_latency", 32'(cyc - sb[0].acc_cyc), 32'(LAT));
                    seen = 1;
                end
                check("rsp_rdata", rsp_rdata, sb[0].rdata);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, sb[0].err});
                check("req_ready_in_resp", {31'b0, req_ready}, 32'h0);
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                         input bit expect_rsp);
        bit   ok = 0;
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            check("accept_timeout", 32'h0, 32'h1);
        end else if (expect_rsp) begin
            e.rdata   = exp_rd;
            e.err     = exp_err;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'h0000_0013;
        req_wdata = 32'h5A5A_5A5A;
        req_be    = 4'hF;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1;
        end
        if (!done) begin
            check("rsp_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
            seen = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
        issue(we, addr, wdata, be, exp_rd, exp_err, 1'b1);
        drain();
    endtask

    initial begin
        bit got;
        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req_ready", {31'b0, req_ready}, 32'h0);
            check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
            check("rst_rsp_rdata", rsp_rdata, 32'h0);
            check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Full store, load back, then lane-wise partial stores
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        txn(1'b1, 32'h10, 32'h0000_1234, 4'b0011, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_1234, 1'b0);
        txn(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_1234, 1'b0);
        txn(1'b1, 32'h10, 32'h7700_0000, 4'b1000, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h77AD_1234, 1'b0);

        // Error cases: misaligned and out of range must not write
        txn(1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1);
        txn(1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0);
        txn(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        txn(1'b1, 32'h2, 32'h1111_1111, 4'hF, 32'h0, 1'b1);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0);
        txn(1'b1, 32'hFFC, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 32'hFFC, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h77AD_1234, 1'b0);

        // Backpressure: response held while rsp_ready is low
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'h77AD_1234, 1'b0, 1'b1);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        check("bp_valid_seen", {31'b0, got}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bp_hold_valid", {31'b0, rsp_valid}, 32'h1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_ready", {31'b0, req_ready}, 32'h1);
        check("bp_release_valid", {31'b0, rsp_valid}, 32'h0);
        @(posedge clk);
        #1;

        // Reset on the would-be commit edge aborts the store
        txn(1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        check("abort_no_rsp", {31'b0, got}, 32'h0);
        @(posedge clk);
        #1;
        txn(1'b0, 32'h20, 32'h0, 4'h0, 32'h1122_3344, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder (slave) end of the data-memory request/response interface driven by the Memory stage of the pipeline core. It accepts one load or store request at a time, inserts a programmable number of wait states, commits byte-enabled writes or reads a word, and returns a response held until the initiator takes it. It replaces the single-cycle data memory when multi-cycle memory latency is modelled, and is instantiated next to the pipeline top alongside the Hazard unit's stall logic.

## Interface
- ADDR_WIDTH, 10, word-address bits; capacity 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait-state cycles between accept and response; legal range 1..15.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept; high only in IDLE and not in reset.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables, bit i enables byte lane [8i+7:8i].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator takes the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata/be, load the counter with LATENCY-1, and go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle. When the counter is 0, perform the access and go to RESP.
- Access at WAIT exit:
  - error = addr[1:0]!=0 or addr[31:2] >= 2^ADDR_WIDTH.
  - Error: no write; rdata=0; err=1.
  - Store: write the enabled lanes of wdata to word addr[ADDR_WIDTH+1:2]; rdata=0; err=0.
  - Load: rdata = the full word (be ignored); err=0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid&&rsp_ready, then go to IDLE. rsp_ready is ignored outside RESP.
- Stores with be=4'b0000 complete normally and change no memory.
- Memory contents are not affected by rst; contents are undefined until written.

## Timing
- Reset values: state=IDLE, req_ready=0 while rst is high, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Reset mid-transaction (WAIT or RESP): the transaction is aborted. A pending store is never committed, because commit happens only at the WAIT->RESP edge. The response is dropped.
- Latency: request accepted at edge E0; rsp_valid is high from the cycle after edge E_LATENCY. With LATENCY=2, rsp_valid rises two cycles after accept.
- Write commit is visible to a load accepted at any later edge. A load reads memory state at its own WAIT exit.
- Minimum issue interval: LATENCY+2 cycles (accept, LATENCY waits, response handshake, return to IDLE). There is no accept in the same cycle as a response handshake.
- Backpressure: rsp_ready low holds RESP indefinitely with outputs frozen.
- req_* inputs are sampled only on the accept edge; changes afterwards are ignored.

## Structure
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - LATENCY_MIN=1 and LATENCY_MAX=15 constants;
  - counter width 4.
- Sub-module dmem_array: synchronous single-port 32-bit RAM with 4-lane byte write enable and combinational read, parameterised by ADDR_WIDTH.
- Top FSM, capture registers, counter and error check live in data_mem_responder.

## Test plan
- Reset then idle: rst high 3 cycles -> req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. After rst drops, req_ready=1 next cycle.
- Store then load, LATENCY=2: store 0xDEADBEEF to 0x10 with be=4'hF, then load 0x10 -> rsp_valid rises 2 cycles after each accept; load returns 0xDEADBEEF, err=0.
- Partial store: 0xDEADBEEF at 0x10, then store 0x00001234 with be=4'b0011, then load -> 0xDEAD1234.
- Errors: load 0x13 (misaligned) -> err=1, rdata=0. Store to 0x1000 with ADDR_WIDTH=10 -> err=1, and a later load of 0x0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable and req_ready=0; release -> IDLE next cycle.
- Reset mid-WAIT: store 0xCAFEF00D to 0x20 and assert rst during WAIT -> no response; a load of 0x20 after reset returns the prior value.
